dat_mem_arbiter: RTL and testbench
==================================

// Module: dat_mem_arbiter
// PURPOSE
//  Owns the single-port DAT RAM and shares it between the controller FSM (ctl_*) and the
//  CSR/software window (csr_*). Zero-fills the table after reset and on a software clear,
//  then arbitrates one access per cycle. Routes 1-cycle read data back to the granted requester.
//  Sits between the i3c core's DAT export interface and the prim_ram_1p_adv DAT instance.
// PARAMETERS
//  Depth        128          DAT entries (matches DAT_DEPTH)
//  Aw           $clog2(Depth) address width
//  Width        64           entry width, bits
//  StarveLimit  4            consecutive CSR losses before CSR is forced to win (>=1)
// PORTS
//  clk_i          in   1      clock
//  rst_i          in   1      synchronous reset, active-high
//  clear_req_i    in   1      pulse: zero-fill whole table
//  init_done_o    out  1      1 = table valid, arbitration running
//  ctl_req_i      in   1      controller request (hold fields stable until gnt)
//  ctl_write_i    in   1      1 = write, 0 = read
//  ctl_addr_i     in   Aw     entry index
//  ctl_wdata_i    in   Width  write data
//  ctl_wmask_i    in   Width  per-bit write enable
//  ctl_gnt_o      out  1      access accepted this cycle
//  ctl_rvalid_o   out  1      read data valid (cycle after read gnt)
//  ctl_rdata_o    out  Width  read data
//  csr_*          --   --     identical set to ctl_* (req/write/addr/wdata/wmask/gnt/rvalid/rdata)
//  mem_req_o      out  1      RAM request
//  mem_write_o    out  1      RAM write
//  mem_addr_o     out  Aw     RAM address
//  mem_wdata_o    out  Width  RAM write data
//  mem_wmask_o    out  Width  RAM write mask
//  mem_rdata_i    in   Width  RAM read data, valid 1 cycle after read req
// BEHAVIOUR
//  Reset (rst_i high at clk edge): state=CLEAR, clr_addr=0, starve_cnt=0, rd_owner=NONE;
//   all gnt/rvalid=0, rdata=0, init_done_o=0. mem_* driven by CLEAR (mem_req_o=1 first cycle out).
//  States: CLEAR, ARB.
//  CLEAR: each cycle mem_req_o=1, write=1, addr=clr_addr, wdata=0, wmask='1; clr_addr++.
//   After addr Depth-1 written -> ARB. Exactly Depth cycles. No grants, no rvalid.
//   clear_req_i ignored. rst_i mid-clear restarts at addr 0.
//  ARB: init_done_o=1. Grant combinational in same cycle as req; mem_* driven from winner;
//   mem_req_o=0 and mem_* fields 0 when no winner.
//   Priority: ctl wins unless starve_cnt==StarveLimit, then csr wins.
//   starve_cnt: +1 when csr_req_i & ctl wins; cleared when csr granted; saturates at StarveLimit.
//   Only one gnt asserted per cycle; never grant when req low.
//  clear_req_i in ARB: takes priority over both requesters that cycle (no gnt),
//   next state CLEAR, clr_addr=0, starve_cnt=0. Pending read return still delivered next cycle.
//  Read return: registered rd_owner from a read gnt; next cycle owner's rvalid=1 and
//   rdata=mem_rdata_i (other port rdata held at last value, rvalid=0). Writes produce no rvalid.
//  Back-to-back reads allowed every cycle (1 outstanding per cycle, fixed 1-cycle latency).
//  Simultaneous write+read to same address on consecutive cycles: RAM ordering, no bypass.
//  Address >= Depth (non-power-of-2 Depth): granted, mem_req_o suppressed, read returns 0.
// TESTING
//  1. Reset, Depth=128: mem writes addr 0..127 data 0 full mask, init_done_o rises cycle 128; no gnt before.
//  2. ctl write addr 5 data 64'hDEAD_BEEF_0123_4567, then csr read addr 5 -> csr_rvalid_o next cycle, data matches; ctl_rvalid_o stays 0.
//  3. ctl_req and csr_req held high continuously -> pattern ctl x4, csr x1 repeating (StarveLimit=4).
//  4. Write mask 64'h0000_0000_FFFF_FFFF over preloaded all-ones -> readback 64'hFFFF_FFFF_xxxx with upper 32 unchanged.
//  5. clear_req_i while ctl read in flight -> read data returned next cycle, then 128 clear cycles, reads return 0.
//  6. rst_i asserted at clr_addr=60 -> sweep restarts at 0, init_done_o only after full 128 cycles.

Source files
------------

// File: rtl/dat_mem_arbiter.sv
// DAT RAM owner: zero-fills the single-port table after reset or a software clear, then
// arbitrates one controller/CSR access per cycle and steers 1-cycle read data back.
module dat_mem_arbiter #(
  parameter int unsigned Depth       = 128,
  parameter int unsigned Aw          = $clog2(Depth),
  parameter int unsigned Width       = 64,
  parameter int unsigned StarveLimit = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             clear_req_i,
  output logic             init_done_o,

  input  logic             ctl_req_i,
  input  logic             ctl_write_i,
  input  logic [Aw-1:0]    ctl_addr_i,
  input  logic [Width-1:0] ctl_wdata_i,
  input  logic [Width-1:0] ctl_wmask_i,
  output logic             ctl_gnt_o,
  output logic             ctl_rvalid_o,
  output logic [Width-1:0] ctl_rdata_o,

  input  logic             csr_req_i,
  input  logic             csr_write_i,
  input  logic [Aw-1:0]    csr_addr_i,
  input  logic [Width-1:0] csr_wdata_i,
  input  logic [Width-1:0] csr_wmask_i,
  output logic             csr_gnt_o,
  output logic             csr_rvalid_o,
  output logic [Width-1:0] csr_rdata_o,

  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic [Aw-1:0]    mem_addr_o,
  output logic [Width-1:0] mem_wdata_o,
  output logic [Width-1:0] mem_wmask_o,
  input  logic [Width-1:0] mem_rdata_i
);

  localparam int unsigned     Sw        = $clog2(StarveLimit + 1);
  localparam logic [Sw-1:0]   StarveMax = Sw'(StarveLimit);
  localparam logic [Aw-1:0]   LastAddr  = Aw'(Depth - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_ARB
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CTL,
    OWN_CSR
  } owner_e;

  state_e          state_q, state_d;
  logic [Aw-1:0]   clr_addr_q, clr_addr_d;
  logic [Sw-1:0]   starve_q, starve_d;
  owner_e          rd_owner_q, rd_owner_d;
  logic            rd_oob_q, rd_oob_d;
  logic [Width-1:0] ctl_rdata_q, csr_rdata_q;
  logic [Width-1:0] rdata_ret;

  logic             ctl_oob, csr_oob;
  logic             win_write, win_oob;
  logic [Aw-1:0]    win_addr;
  logic [Width-1:0] win_wdata, win_wmask;

  // Entries past Depth only exist when Depth is not a power of two.
  if (Depth == (1 << Aw)) begin : g_pow2
    assign ctl_oob = 1'b0;
    assign csr_oob = 1'b0;
  end else begin : g_npow2
    localparam logic [Aw:0] DepthW = (Aw + 1)'(Depth);
    assign ctl_oob = {1'b0, ctl_addr_i} >= DepthW;
    assign csr_oob = {1'b0, csr_addr_i} >= DepthW;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    starve_d    = starve_q;
    rd_owner_d  = OWN_NONE;
    rd_oob_d    = 1'b0;
    init_done_o = 1'b0;
    ctl_gnt_o   = 1'b0;
    csr_gnt_o   = 1'b0;
    win_write   = 1'b0;
    win_oob     = 1'b0;
    win_addr    = '0;
    win_wdata   = '0;
    win_wmask   = '0;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = clr_addr_q;
        mem_wmask_o = '1;
        if (clr_addr_q == LastAddr) begin
          state_d    = ST_ARB;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + Aw'(1);
        end
      end

      ST_ARB: begin
        init_done_o = 1'b1;
        if (clear_req_i) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          starve_d   = '0;
        end else begin
          // The controller normally wins; a starved CSR port gets exactly one turn.
          ctl_gnt_o = ctl_req_i & ~(csr_req_i & (starve_q == StarveMax));
          csr_gnt_o = csr_req_i & ~ctl_gnt_o;

          if (ctl_gnt_o) begin
            win_write = ctl_write_i;
            win_oob   = ctl_oob;
            win_addr  = ctl_addr_i;
            win_wdata = ctl_wdata_i;
            win_wmask = ctl_wmask_i;
            if (!ctl_write_i) rd_owner_d = OWN_CTL;
          end else if (csr_gnt_o) begin
            win_write = csr_write_i;
            win_oob   = csr_oob;
            win_addr  = csr_addr_i;
            win_wdata = csr_wdata_i;
            win_wmask = csr_wmask_i;
            if (!csr_write_i) rd_owner_d = OWN_CSR;
          end

          if ((ctl_gnt_o || csr_gnt_o) && !win_oob) begin
            mem_req_o   = 1'b1;
            mem_write_o = win_write;
            mem_addr_o  = win_addr;
            mem_wdata_o = win_wdata;
            mem_wmask_o = win_wmask;
          end
          rd_oob_d = (rd_owner_d != OWN_NONE) && win_oob;

          if (csr_gnt_o) begin
            starve_d = '0;
          end else if (csr_req_i && ctl_gnt_o && starve_q != StarveMax) begin
            starve_d = starve_q + Sw'(1);
          end
        end
      end
    endcase
  end

  // Out-of-range reads never touched the RAM, so they return zero instead of stale data.
  assign rdata_ret    = rd_oob_q ? '0 : mem_rdata_i;
  assign ctl_rvalid_o = (rd_owner_q == OWN_CTL);
  assign csr_rvalid_o = (rd_owner_q == OWN_CSR);
  assign ctl_rdata_o  = ctl_rvalid_o ? rdata_ret : ctl_rdata_q;
  assign csr_rdata_o  = csr_rvalid_o ? rdata_ret : csr_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      starve_q    <= '0;
      rd_owner_q  <= OWN_NONE;
      rd_oob_q    <= 1'b0;
      // NOTE: the held read-data registers are reset too, since their value is visible on the ports.
      ctl_rdata_q <= '0;
      csr_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
      rd_oob_q   <= rd_oob_d;
      if (ctl_rvalid_o) ctl_rdata_q <= rdata_ret;
      if (csr_rvalid_o) csr_rdata_q <= rdata_ret;
    end
  end

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Self-checking bench for dat_mem_arbiter: behavioural RAM, reference table model and
// read-return scoreboard, plus directed clear/arbitration/mask/reset scenarios.
module tb_dat_mem_arbiter;

  localparam int Aw = 7;
  localparam int W  = 64;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clear_req_i;
  logic          init_done_o;
  logic          ctl_req_i, ctl_write_i, ctl_gnt_o, ctl_rvalid_o;
  logic [Aw-1:0] ctl_addr_i;
  logic [W-1:0]  ctl_wdata_i, ctl_wmask_i, ctl_rdata_o;
  logic          csr_req_i, csr_write_i, csr_gnt_o, csr_rvalid_o;
  logic [Aw-1:0] csr_addr_i;
  logic [W-1:0]  csr_wdata_i, csr_wmask_i, csr_rdata_o;
  logic          mem_req_o, mem_write_o;
  logic [Aw-1:0] mem_addr_o;
  logic [W-1:0]  mem_wdata_o, mem_wmask_o, mem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  dat_mem_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_req_i  (clear_req_i),
    .init_done_o  (init_done_o),
    .ctl_req_i    (ctl_req_i),
    .ctl_write_i  (ctl_write_i),
    .ctl_addr_i   (ctl_addr_i),
    .ctl_wdata_i  (ctl_wdata_i),
    .ctl_wmask_i  (ctl_wmask_i),
    .ctl_gnt_o    (ctl_gnt_o),
    .ctl_rvalid_o (ctl_rvalid_o),
    .ctl_rdata_o  (ctl_rdata_o),
    .csr_req_i    (csr_req_i),
    .csr_write_i  (csr_write_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_wmask_i  (csr_wmask_i),
    .csr_gnt_o    (csr_gnt_o),
    .csr_rvalid_o (csr_rvalid_o),
    .csr_rdata_o  (csr_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wmask_o  (mem_wmask_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural single-port RAM with per-bit mask and 1-cycle read latency.
  logic [W-1:0] ram [128];
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_write_o) ram[mem_addr_o] <= (ram[mem_addr_o] & ~mem_wmask_o) | (mem_wdata_o & mem_wmask_o);
      else             mem_rdata_i     <= ram[mem_addr_o];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard, sampled on the falling edge.
  logic [W-1:0]  ref_mem [128];
  logic [W-1:0]  ctl_q [$];
  logic [W-1:0]  csr_q [$];
  logic          exp_clearing, exp_ctl_rv, exp_csr_rv, e_ctl, e_csr, w;
  logic [Aw-1:0] exp_clr_addr, a;
  logic [W-1:0]  exp_ctl_last, exp_csr_last, d, m;
  int            exp_starve;

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_clearing = 1'b1;
      exp_clr_addr = '0;
      exp_starve   = 0;
      exp_ctl_rv   = 1'b0;
      exp_csr_rv   = 1'b0;
      exp_ctl_last = '0;
      exp_csr_last = '0;
      ctl_q.delete();
      csr_q.delete();
    end else begin
      check("ctl_rvalid", ctl_rvalid_o, exp_ctl_rv);
      check("csr_rvalid", csr_rvalid_o, exp_csr_rv);
      if (exp_ctl_rv && ctl_q.size() > 0) exp_ctl_last = ctl_q.pop_front();
      if (exp_csr_rv && csr_q.size() > 0) exp_csr_last = csr_q.pop_front();
      check("ctl_rdata", ctl_rdata_o, exp_ctl_last);
      check("csr_rdata", csr_rdata_o, exp_csr_last);
      exp_ctl_rv = 1'b0;
      exp_csr_rv = 1'b0;

      if (exp_clearing) begin
        check("clr_init_done", init_done_o, 1'b0);
        check("clr_gnt", {ctl_gnt_o, csr_gnt_o}, 2'b00);
        check("clr_mem_ctrl", {mem_req_o, mem_write_o, mem_addr_o}, {2'b11, exp_clr_addr});
        check("clr_mem_wdata", mem_wdata_o, 64'h0);
        check("clr_mem_wmask", mem_wmask_o, {64{1'b1}});
        ref_mem[exp_clr_addr] = '0;
        if (exp_clr_addr == 7'd127) exp_clearing = 1'b0;
        exp_clr_addr = exp_clr_addr + 7'd1;
      end else begin
        check("arb_init_done", init_done_o, 1'b1);
        e_ctl = !clear_req_i && ctl_req_i && !(csr_req_i && exp_starve == 4);
        e_csr = !clear_req_i && csr_req_i && !e_ctl;
        check("gnt", {ctl_gnt_o, csr_gnt_o}, {e_ctl, e_csr});
        w = e_ctl ? ctl_write_i : csr_write_i;
        a = e_ctl ? ctl_addr_i  : csr_addr_i;
        d = e_ctl ? ctl_wdata_i : csr_wdata_i;
        m = e_ctl ? ctl_wmask_i : csr_wmask_i;
        if (e_ctl || e_csr) begin
          check("mem_ctrl", {mem_req_o, mem_write_o, mem_addr_o}, {1'b1, w, a});
          if (w) begin
            check("mem_wdata", mem_wdata_o, d);
            check("mem_wmask", mem_wmask_o, m);
            ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
          end else if (e_ctl) begin
            ctl_q.push_back(ref_mem[a]);
            exp_ctl_rv = 1'b1;
          end else begin
            csr_q.push_back(ref_mem[a]);
            exp_csr_rv = 1'b1;
          end
        end else begin
          check("mem_idle", mem_req_o, 1'b0);
        end
        if (clear_req_i || e_csr)                   exp_starve = 0;
        else if (csr_req_i && e_ctl && exp_starve < 4) exp_starve++;
        if (clear_req_i) begin
          exp_clearing = 1'b1;
          exp_clr_addr = '0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit is_csr, input logic req, input logic wr, input logic [Aw-1:0] addr,
                       input logic [W-1:0] wdata, input logic [W-1:0] wmask);
    if (is_csr) begin
      csr_req_i = req; csr_write_i = wr; csr_addr_i = addr; csr_wdata_i = wdata; csr_wmask_i = wmask;
    end else begin
      ctl_req_i = req; ctl_write_i = wr; ctl_addr_i = addr; ctl_wdata_i = wdata; ctl_wmask_i = wmask;
    end
  endtask

  // Holds a request until granted; returns one tick after the accepting edge.
  task automatic access(input bit is_csr, input logic wr, input logic [Aw-1:0] addr,
                        input logic [W-1:0] wdata, input logic [W-1:0] wmask);
    int n = 0;
    drive(is_csr, 1'b1, wr, addr, wdata, wmask);
    #2;
    while (!(is_csr ? csr_gnt_o : ctl_gnt_o) && n < 50) begin
      @(posedge clk_i);
      #3;
      n++;
    end
    check("gnt_timeout", n >= 50, 1'b0);
    step();
    drive(is_csr, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done_o && n < 300) begin
      step();
      n++;
    end
    check(tag, n, 128);
  endtask

  logic [9:0] pat_ctl, pat_csr;

  initial begin
    rst_i = 1'b1;
    clear_req_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) step();
    check("rst_init_done", init_done_o, 1'b0);
    check("rst_rvalid", {ctl_rvalid_o, csr_rvalid_o}, 2'b00);
    check("rst_rdata", ctl_rdata_o | csr_rdata_o, 64'h0);
    rst_i = 1'b0;

    // Zero-fill sweep after reset.
    wait_init("t1_init_cycles");

    // Controller write, CSR read-back of the same entry.
    access(1'b0, 1'b1, 7'd5, 64'hDEAD_BEEF_0123_4567, {64{1'b1}});
    access(1'b1, 1'b0, 7'd5, '0, '0);
    check("t2_csr_rvalid", csr_rvalid_o, 1'b1);
    check("t2_ctl_rvalid", ctl_rvalid_o, 1'b0);
    check("t2_csr_rdata", csr_rdata_o, 64'hDEAD_BEEF_0123_4567);

    // Both ports requesting continuously: four controller wins, then one CSR win.
    drive(1'b0, 1'b1, 1'b0, 7'd5, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 7'd6, '0, '0);
    for (int i = 0; i < 10; i++) begin
      #2;
      pat_ctl = {pat_ctl[8:0], ctl_gnt_o};
      pat_csr = {pat_csr[8:0], csr_gnt_o};
      @(posedge clk_i);
      #1;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    check("t3_ctl_pattern", pat_ctl, 10'b1111011110);
    check("t3_csr_pattern", pat_csr, 10'b0000100001);
    step();

    // Partial write mask over an all-ones entry.
    access(1'b0, 1'b1, 7'd10, {64{1'b1}}, {64{1'b1}});
    access(1'b1, 1'b1, 7'd10, 64'h1111_1111_A5A5_5A5A, 64'h0000_0000_FFFF_FFFF);
    access(1'b0, 1'b0, 7'd10, '0, '0);
    check("t4_rvalid", ctl_rvalid_o, 1'b1);
    check("t4_rdata", ctl_rdata_o, 64'hFFFF_FFFF_A5A5_5A5A);

    // Software clear while a controller read is returning; CSR request must be ignored.
    access(1'b0, 1'b0, 7'd5, '0, '0);
    clear_req_i = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 7'd0, '0, '0);
    check("t5_inflight_rvalid", ctl_rvalid_o, 1'b1);
    check("t5_inflight_rdata", ctl_rdata_o, 64'hDEAD_BEEF_0123_4567);
    #2;
    check("t5_clear_no_gnt", {ctl_gnt_o, csr_gnt_o}, 2'b00);
    step();
    clear_req_i = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    wait_init("t5_clear_cycles");
    access(1'b0, 1'b0, 7'd5, '0, '0);
    check("t5_ctl_zero", ctl_rdata_o, 64'h0);
    access(1'b1, 1'b0, 7'd10, '0, '0);
    check("t5_csr_zero", csr_rdata_o, 64'h0);

    // Reset in the middle of a sweep restarts it from entry 0.
    access(1'b0, 1'b1, 7'd7, 64'h0F0F_0F0F_0F0F_0F0F, {64{1'b1}});
    clear_req_i = 1'b1;
    step();
    clear_req_i = 1'b0;
    repeat (60) step();
    check("t6_sweep_at_60", mem_addr_o, 7'd60);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("t6_restart_addr", mem_addr_o, 7'd0);
    wait_init("t6_init_cycles");
    access(1'b0, 1'b0, 7'd7, '0, '0);
    check("t6_rdata_zero", ctl_rdata_o, 64'h0);

    repeat (2) step();
    check("ctl_queue_empty", ctl_q.size(), 0);
    check("csr_queue_empty", csr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
